// File: rtl/pattern_reader.sv
// pattern_reader: Avalon-MM burst read master that replays a frame region into a
// first-word-fall-through FIFO and presents it on a valid/ready stream.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no burst outstanding; request when enabled and a whole burst fits
// REQ   | master_read asserted, holding request until waitrequest drops
// DATA  | burst accepted, collecting BURST_COUNT beats into the FIFO
module pattern_reader #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int BURST_COUNT = 8,
    parameter int BURST_WIDTH = 4,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = 32'h38000000,
    parameter int FRAME_BURSTS = 65536,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDRESS_WIDTH-1:0]     master_address,
    output logic                         master_read,
    output logic [BURST_WIDTH-1:0]       master_burstcount,
    output logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable,
    input  logic [DATA_WIDTH-1:0]        master_readdata,
    input  logic                         master_readdatavalid,
    input  logic                         master_waitrequest,
    input  logic                         enable,
    output logic [DATA_WIDTH-1:0]        st_data,
    output logic                         st_valid,
    input  logic                         st_ready,
    output logic                         frame_done,
    output logic                         busy,
    output logic                         protocol_err
);

    localparam int BEAT_W = $clog2(BURST_COUNT);
    localparam int BCNT_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [BEAT_W-1:0]        LAST_BEAT   = BEAT_W'(BURST_COUNT - 1);
    localparam logic [BCNT_W-1:0]        LAST_BURST  = BCNT_W'(FRAME_BURSTS - 1);
    localparam logic [ADDRESS_WIDTH-1:0] BURST_BYTES = ADDRESS_WIDTH'(BURST_COUNT * BYTE_ENABLE_WIDTH);
    localparam logic [CNT_W-1:0]         DEPTH       = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]         CREDIT      = CNT_W'(BURST_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } state_t;

    state_t state, state_next;

    logic [BEAT_W-1:0]     beat_cnt;
    logic [BCNT_W-1:0]     burst_cnt;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      fifo_free;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic beat_in;
    logic last_beat;
    logic frame_end;
    logic stray_beat;
    logic push;
    logic pop;

    assign fifo_free = DEPTH - fifo_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        beat_in     = 1'b0;
        last_beat   = 1'b0;
        frame_end   = 1'b0;
        stray_beat  = 1'b0;
        master_read = 1'b0;
        busy        = 1'b1;
        case (state)
            IDLE: begin
                busy       = 1'b0;
                stray_beat = master_readdatavalid;
                if (enable && (fifo_free >= CREDIT)) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                master_read = 1'b1;
                stray_beat  = master_readdatavalid;
                if (!master_waitrequest) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                beat_in   = master_readdatavalid;
                last_beat = beat_in && (beat_cnt == LAST_BEAT);
                frame_end = last_beat && (burst_cnt == LAST_BURST);
                if (last_beat) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign frame_done        = frame_end;
    assign master_burstcount = BURST_WIDTH'(BURST_COUNT);
    assign master_byteenable = '1;

    // Address and burst counter advance only once the final beat of a burst has landed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            master_address <= BASE_ADDRESS;
            beat_cnt       <= '0;
            burst_cnt      <= '0;
            protocol_err   <= 1'b0;
        end else begin
            if (stray_beat) begin
                protocol_err <= 1'b1;
            end
            if (beat_in) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    if (frame_end) begin
                        master_address <= BASE_ADDRESS;
                        burst_cnt      <= '0;
                    end else begin
                        master_address <= master_address + BURST_BYTES;
                        burst_cnt      <= burst_cnt + 1'b1;
                    end
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    // Credit check in IDLE guarantees a push never lands on a full FIFO.
    assign push = beat_in;
    assign pop  = st_valid && st_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= master_readdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign st_data  = mem[rd_ptr];
    assign st_valid = (fifo_count != '0);

endmodule

// File: doc/pattern_reader.md
Name: pattern_reader

Overview:
Avalon-MM burst read master that streams back the frame region filled by the team's pattern-generating write master, starting at 0x38000000. It issues fixed-length read bursts, buffers the returned beats in a small FIFO, and presents them on a valid/ready stream for checking or display. It runs continuously while enabled, wrapping to the base address after one full frame, and flags each frame boundary.

Parameters:
ADDRESS_WIDTH, 32, Avalon address width in bits.
DATA_WIDTH, 32, Avalon and stream data width in bits.
BYTE_ENABLE_WIDTH, 4, DATA_WIDTH/8.
BURST_COUNT, 8, beats per burst; power of 2, 2 to 64.
BURST_WIDTH, 4, width of master_burstcount; must hold BURST_COUNT.
BASE_ADDRESS, 32'h38000000, frame start byte address.
FRAME_BURSTS, 65536, bursts per frame.
FIFO_DEPTH, 16, read-data FIFO entries; power of 2, at least BURST_COUNT.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
master_address  out  ADDRESS_WIDTH  burst start byte address
master_read  out  1  read request
master_burstcount  out  BURST_WIDTH  constant BURST_COUNT
master_byteenable  out  BYTE_ENABLE_WIDTH  all ones
master_readdata  in  DATA_WIDTH  returned beat
master_readdatavalid  in  1  beat valid
master_waitrequest  in  1  slave stall
enable  in  1  run request
st_data  out  DATA_WIDTH  FIFO head
st_valid  out  1  FIFO non-empty
st_ready  in  1  sink accepts st_data
frame_done  out  1  one-cycle pulse on last beat of the frame
busy  out  1  high outside IDLE
protocol_err  out  1  sticky: readdatavalid with no burst outstanding

Behaviour:
- Reset: master_address=BASE_ADDRESS, master_read=0, master_burstcount=BURST_COUNT, FIFO empty (st_valid=0), frame_done=0, busy=0, protocol_err=0, burst counter=0, beat counter=0, state=IDLE. Reset mid-burst discards all in-flight and buffered data. protocol_err clears only on reset.
- FSM states are IDLE, REQ and DATA. Exactly one burst is outstanding at most.
- IDLE: if enable=1 and FIFO free entries >= BURST_COUNT, assert master_read next cycle and go to REQ. Otherwise stay.
- REQ: hold master_address, master_read and master_burstcount stable while master_waitrequest=1. On master_read=1 and master_waitrequest=0 (accepted), deassert master_read next cycle and go to DATA.
- DATA: each master_readdatavalid=1 pushes master_readdata into the FIFO and increments the beat counter.
- On beat BURST_COUNT:
  - clear the beat counter;
  - add BURST_COUNT*BYTE_ENABLE_WIDTH to master_address;
  - increment the burst counter.
  - If this was burst FRAME_BURSTS-1: reload master_address to BASE_ADDRESS, clear the burst counter, pulse frame_done in the same cycle as that beat's FIFO write.
  - Then go to IDLE. IDLE re-issues one cycle later if enable and credit allow, so there is one idle cycle between bursts.
- Credit rule: a burst is only requested when the whole burst fits in the FIFO. The FIFO must never overflow, and master_readdatavalid is never back-pressured.
- enable deasserted during REQ or DATA: the current burst completes normally, then the block stays in IDLE. Address and burst counter are retained, so re-enable resumes at the next burst.
- master_readdatavalid in IDLE or REQ: data is dropped and protocol_err is set.
- FIFO is first-word fall-through. A pop occurs on st_valid & st_ready. A simultaneous push and pop leaves the count unchanged. A push into an empty FIFO is visible on st_valid the next cycle.
- The stream preserves beat order exactly. There is no gap insertion or data modification.
- Address arithmetic is modulo 2^ADDRESS_WIDTH.
- master_byteenable is all ones and master_burstcount is constant BURST_COUNT at all times.

Test Plan:
- Reset, then enable=1, waitrequest=0, st_ready=1, slave returns 8 beats 1 cycle after accept. Required: first request at 0x38000000 with burstcount 8; second request at 0x38000020; st_data order matches the returned beats.
- waitrequest held high for 5 cycles on the first request. Required: address, read and burstcount stay stable for all 5 cycles; exactly one accept; read drops the cycle after the accept.
- st_ready=0 throughout. Required: after 2 bursts (16 entries) no new request issues and no beat is lost; after st_ready=1 drains 8 entries, the next request appears at 0x38000040.
- FRAME_BURSTS=4. Required: frame_done pulses exactly on the 32nd beat; the 5th request address is 0x38000000.
- enable dropped mid-DATA after beat 3. Required: beats 4 to 8 are still accepted, then the block is idle with busy=0; re-enable issues at 0x38000020.
- readdatavalid pulsed while IDLE. Required: protocol_err=1 and stays 1; FIFO count unchanged; asynchronous reset mid-burst clears FIFO, address and protocol_err immediately.
